// File: rtl/serial_tx_frame.sv
// serial_tx_frame: parallel-to-serial frame transmitter.
// Sends one frame per accepted start: a low start bit, WIDTH data bits
// LSB-first, then a high stop bit. Each bit is held for CLKS_PER_BIT cycles.
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous reset, active-high
//   data_in - word to send, sampled only on the accepting start cycle
//   start   - transmit request, level-sampled, ignored while busy
//   tx_out  - serial line, idles high (registered)
//   busy    - frame in progress (registered)
//   done    - one-cycle pulse in the first idle cycle after a frame (registered)
module serial_tx_frame #(
    parameter int unsigned WIDTH        = 15,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             start,
    output logic             tx_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cyc_cnt, cyc_nx;
    logic [BW-1:0]    bit_cnt, bit_nx;
    logic [WIDTH-1:0] shift_reg, shift_nx;
    logic [WIDTH-1:0] shifted;
    logic             tx_nx, busy_nx, done_nx;
    logic             cyc_end;

    // State and all outputs are registered; reset abandons any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cyc_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx_out    <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            cyc_cnt   <= cyc_nx;
            bit_cnt   <= bit_nx;
            shift_reg <= shift_nx;
            tx_out    <= tx_nx;
            busy      <= busy_nx;
            done      <= done_nx;
        end
    end

    // Next-state and next-output logic; tx_nx is the line level for the next cycle.
    always_comb begin
        state_nx = state;
        cyc_nx   = cyc_cnt;
        bit_nx   = bit_cnt;
        shift_nx = shift_reg;
        tx_nx    = tx_out;
        busy_nx  = busy;
        done_nx  = 1'b0;
        cyc_end  = (cyc_cnt == CYC_LAST);
        shifted  = shift_reg >> 1;

        case (state)
            IDLE: begin
                tx_nx   = 1'b1;
                busy_nx = 1'b0;
                cyc_nx  = '0;
                bit_nx  = '0;
                if (start) begin
                    shift_nx = data_in;
                    state_nx = START;
                    busy_nx  = 1'b1;
                    tx_nx    = 1'b0;
                end
            end
            START: begin
                if (cyc_end) begin
                    cyc_nx   = '0;
                    bit_nx   = '0;
                    state_nx = DATA;
                    tx_nx    = shift_reg[0];
                end else begin
                    cyc_nx = cyc_cnt + CW'(1);
                end
            end
            DATA: begin
                if (cyc_end) begin
                    cyc_nx = '0;
                    if (bit_cnt == BIT_LAST) begin
                        state_nx = STOP;
                        tx_nx    = 1'b1;
                    end else begin
                        // shift_reg[0] is always the bit currently on the line
                        shift_nx = shifted;
                        tx_nx    = shifted[0];
                        bit_nx   = bit_cnt + BW'(1);
                    end
                end else begin
                    cyc_nx = cyc_cnt + CW'(1);
                end
            end
            STOP: begin
                if (cyc_end) begin
                    cyc_nx   = '0;
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end else begin
                    cyc_nx = cyc_cnt + CW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule
